// File: rtl/data_ram_if.sv
// Bus bundle for the data memory: shared address, write data, write strobe and registered read data.
// The load/store unit drives the master side and the memory sits on the slave side.
interface data_ram_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] addr;
   logic              wr;
   logic [DATA_W-1:0] out;

   modport master (
      output data,
      output addr,
      output wr,
      input  out
   );

   modport slave (
      input  data,
      input  addr,
      input  wr,
      output out
   );
endinterface

// File: rtl/data_ram.sv
// Single-port word-addressed data memory with synchronous write and registered, write-first read.
// Out-of-range addresses are dropped on write and read back as zero.
module data_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic        clk,
   input  logic        rst,
   data_ram_if.slave   bus
);
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   // NOTE: the array has no reset; its power-up zeroes come from the declaration so it can still map to RAM.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] out_d;
   logic              in_range;
   logic              wr_en;
   logic [IDX_W-1:0]  idx;

   // Range test uses every address bit, so e.g. DEPTH+1 never aliases onto word 1.
   always_comb begin
      in_range = (bus.addr < DEPTH_A);
      idx      = bus.addr[IDX_W-1:0];
      wr_en    = bus.wr && in_range && !rst;
      out_d    = '0;
      if (in_range) begin
         out_d = bus.wr ? bus.data : mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx] <= bus.data;
      end
   end

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out = out_q;
endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: a reference memory model predicts each cycle's read data,
// the prediction is queued as stimulus is applied and compared once the edge has produced it.
module tb_data_ram;
   localparam int DEPTH = 256;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   exp_t        sb_q[$];
   logic [31:0] model [DEPTH];

   data_ram_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   data_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, predict the registered output, then compare after the edge.
   task automatic step(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      rst      = r;
      bus.wr   = w;
      bus.addr = a;
      bus.data = d;
      e.tag = tag;
      if (r)                e.exp = '0;
      else if (a >= DEPTH)  e.exp = '0;
      else if (w)           e.exp = d;
      else                  e.exp = model[a];
      if (!r && w && a < DEPTH) model[a] = d;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, bus.out, e.exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      rst      = 1'b1;
      bus.wr   = 1'b0;
      bus.addr = '0;
      bus.data = '0;
      @(negedge clk);

      // Reset blocks writes and clears out.
      step("rst_0", 1'b1, 1'b1, 32'd1, 32'hDEAD);
      step("rst_1", 1'b1, 1'b1, 32'd1, 32'hDEAD);
      step("rst_rd1", 1'b0, 1'b0, 32'd1, 32'h0);

      // Write sequence, each held for two edges, then read back.
      for (int k = 0; k < 2; k++) step("wr1", 1'b0, 1'b1, 32'd1, 32'd1);
      for (int k = 0; k < 2; k++) step("wr2", 1'b0, 1'b1, 32'd2, 32'd2);
      for (int k = 0; k < 2; k++) step("wr0", 1'b0, 1'b1, 32'd0, 32'd0);
      step("rd0", 1'b0, 1'b0, 32'd0, 32'h0);
      step("rd1", 1'b0, 1'b0, 32'd1, 32'h0);
      step("rd2", 1'b0, 1'b0, 32'd2, 32'h0);

      // Mid-cycle address change must not reach out until the next edge.
      step("lat_a1", 1'b0, 1'b0, 32'd1, 32'h0);
      bus.addr = 32'd2;
      #3;
      check("lat_hold", bus.out, model[1]);
      step("lat_a2", 1'b0, 1'b0, 32'd2, 32'h0);

      // Write-first on the same edge.
      step("wf_wr5", 1'b0, 1'b1, 32'd5, 32'h12345678);
      step("wf_rd5", 1'b0, 1'b0, 32'd5, 32'h0);

      // Out-of-range accesses, including addresses that would alias if truncated.
      step("oob_wr256", 1'b0, 1'b1, 32'd256, 32'hFFFFFFFF);
      step("oob_wr257", 1'b0, 1'b1, 32'd257, 32'hFFFFFFFF);
      step("oob_wrmax", 1'b0, 1'b1, 32'hFFFF_FF05, 32'hFFFFFFFF);
      step("oob_rd256", 1'b0, 1'b0, 32'd256, 32'h0);
      step("oob_rd0", 1'b0, 1'b0, 32'd0, 32'h0);
      step("oob_rd1", 1'b0, 1'b0, 32'd1, 32'h0);
      step("oob_rd5", 1'b0, 1'b0, 32'd5, 32'h0);
      step("oob_rdtop", 1'b0, 1'b0, 32'd255, 32'h0);

      // Reset mid-operation keeps memory contents.
      step("mid_wr3", 1'b0, 1'b1, 32'd3, 32'hA5A5A5A5);
      step("mid_rst", 1'b1, 1'b0, 32'd3, 32'h0);
      step("mid_rd3", 1'b0, 1'b0, 32'd3, 32'h0);

      // Top word boundary.
      step("top_wr", 1'b0, 1'b1, 32'd255, 32'hCAFEF00D);
      step("top_rd", 1'b0, 1'b0, 32'd255, 32'h0);

      // Mixed random traffic over a small window plus occasional out-of-range addresses.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         logic        w;
         a = 32'($urandom_range(0, 9));
         if (a == 32'd8) a = 32'd256 + 32'($urandom_range(0, 3));
         if (a == 32'd9) a = 32'd254 + 32'($urandom_range(0, 1));
         w = ($urandom_range(0, 2) == 0);
         step("rand", 1'b0, w, a, $urandom());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
